// File: rtl/grf_mp_if.sv
// Register-file access bundle: decode-side read/issue ports and the writeback port.
interface grf_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rd_busy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic                 flush;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_addr, flush,
    input  rd, rd_busy
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_addr, flush,
    output rd, rd_busy
  );
endinterface

// File: rtl/grf_mp.sv
// Multi-read-port register file with a per-register busy scoreboard for RAW detection.
// Define GRF_BYPASS_EN to forward same-cycle writeback data (and clear busy) onto matching read ports.
module grf_mp #(
  parameter int              WIDTH   = 32,
  parameter int              DEPTH   = 32,
  parameter int              NRD     = 2,
  parameter int              GP_IDX  = 28,
  parameter logic [WIDTH-1:0] GP_INIT = 32'h0000_1800,
  parameter int              SP_IDX  = 29,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h0000_2ffc
) (
  input logic    clk,
  input logic    reset,
  grf_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [DEPTH-1:0][WIDTH-1:0] image_t;

  function automatic image_t reset_image();
    image_t img;
    img         = '0;
    img[GP_IDX] = GP_INIT;
    img[SP_IDX] = SP_INIT;
    return img;
  endfunction

  // Register 0 and out-of-range addresses behave as a hard-wired zero.
  function automatic logic addr_ok(logic [AW-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  // Declaration initialisers give the reset image at time zero, before any reset edge.
  image_t           regs = reset_image();
  logic [DEPTH-1:0] busy = '0;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = bus.we && addr_ok(bus.wa);
  assign iss_ok = bus.iss_valid && addr_ok(bus.iss_addr);

  // Issue is applied last so a new producer survives a same-cycle clear or flush.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush)
      busy_nxt = '0;
    else if (wr_ok)
      busy_nxt[bus.wa] = 1'b0;
    if (iss_ok)
      busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= reset_image();
      busy <= '0;
    end else begin
      if (wr_ok)
        regs[bus.wa] <= bus.wd;
      busy <= busy_nxt;
    end
  end

  logic [NRD*WIDTH-1:0] rd_v;
  logic [NRD-1:0]       busy_v;
  logic [AW-1:0]        a;

  always_comb begin
    rd_v   = '0;
    busy_v = '0;
    a      = '0;
    for (int k = 0; k < NRD; k++) begin
      a = bus.ra[k*AW +: AW];
      if (addr_ok(a)) begin
        rd_v[k*WIDTH +: WIDTH] = regs[a];
        busy_v[k]              = busy[a];
`ifdef GRF_BYPASS_EN
        if (wr_ok && !reset && (a == bus.wa)) begin
          rd_v[k*WIDTH +: WIDTH] = bus.wd;
          busy_v[k]              = 1'b0;
        end
`else
`endif
      end
    end
  end

  assign bus.rd      = rd_v;
  assign bus.rd_busy = busy_v;
endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: directed scenarios plus randomized traffic against a reference model.
module tb_grf_mp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  grf_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) bus ();

  grf_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_reg  [DEPTH];
  logic        m_busy [DEPTH];

`ifdef GRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_reg[28] = 32'h0000_1800;
    m_reg[29] = 32'h0000_2ffc;
  endtask

  // One clock edge worth of register-file behaviour, from the documented rules.
  task automatic model_edge();
    int wa, ia;
    wa = int'(bus.wa);
    ia = int'(bus.iss_addr);
    if (reset) begin
      model_reset();
    end else begin
      if (bus.we && wa != 0) m_reg[wa] = bus.wd;
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else if (bus.we && wa != 0) begin
        m_busy[wa] = 1'b0;
      end
      if (bus.iss_valid && ia != 0) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic exp_read(input int a, output logic [31:0] d, output logic b);
    if (a == 0) begin
      d = 32'h0;
      b = 1'b0;
    end else if (BYPASS && bus.we && !reset && int'(bus.wa) == a) begin
      d = bus.wd;
      b = 1'b0;
    end else begin
      d = m_reg[a];
      b = m_busy[a];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic idle();
    bus.we = 1'b0;
    bus.iss_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  // Check every port against the model, then advance one clock.
  task automatic tick();
    logic [31:0] d;
    logic        b;
    #1;
    for (int k = 0; k < NRD; k++) begin
      exp_read(int'(bus.ra[k*AW +: AW]), d, b);
      chk($sformatf("model_rd%0d", k), bus.rd[k*WIDTH +: WIDTH], d);
      chk($sformatf("model_busy%0d", k), {31'b0, bus.rd_busy[k]}, {31'b0, b});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    idle();
    bus.wa = '0; bus.wd = '0; bus.iss_addr = '0;
    set_ra(28, 29);
    #1;
    chk("init_gp", bus.rd[31:0], 32'h0000_1800);
    chk("init_sp", bus.rd[63:32], 32'h0000_2ffc);
    tick();
    chk("rst_gp", bus.rd[31:0], 32'h0000_1800);
    chk("rst_sp", bus.rd[63:32], 32'h0000_2ffc);
    chk("rst_busy", {30'b0, bus.rd_busy}, 32'h0);
    reset = 1'b0;
    set_ra(5, 0);
    #1 chk("rst_r5", bus.rd[31:0], 32'h0);

    bus.we = 1'b1; bus.wa = 5; bus.wd = 32'hDEAD_BEEF;
    tick();
    idle(); set_ra(5, 5);
    #1 chk("wr_r5", bus.rd[63:32], 32'hDEAD_BEEF);
    bus.we = 1'b1; bus.wa = 0; bus.wd = 32'h1234;
    tick();
    idle(); set_ra(0, 0);
    #1 chk("wr_r0", bus.rd[31:0], 32'h0);

    bus.iss_valid = 1'b1; bus.iss_addr = 8; set_ra(8, 8);
    #1 chk("iss_same_cycle", {30'b0, bus.rd_busy}, 32'h0);
    tick();
    idle();
    #1 chk("iss_busy", {30'b0, bus.rd_busy}, 32'h3);
    bus.we = 1'b1; bus.wa = 8; bus.wd = 32'h8888_0001;
    tick();
    idle();
    #1 chk("wb_clear", {30'b0, bus.rd_busy}, 32'h0);
    bus.we = 1'b1; bus.wa = 8; bus.wd = 32'h8888_0002;
    bus.iss_valid = 1'b1; bus.iss_addr = 8;
    tick();
    idle();
    #1 chk("iss_beats_wb", {30'b0, bus.rd_busy}, 32'h3);

    bus.iss_valid = 1'b1; bus.iss_addr = 3;
    tick();
    bus.iss_valid = 1'b0;
    bus.we = 1'b1; bus.wa = 3; bus.wd = 32'hA5A5_A5A5; set_ra(3, 3);
    #1;
    if (BYPASS) begin
      chk("byp_rd0", bus.rd[31:0], 32'hA5A5_A5A5);
      chk("byp_rd1", bus.rd[63:32], 32'hA5A5_A5A5);
      chk("byp_busy", {30'b0, bus.rd_busy}, 32'h0);
    end else begin
      chk("nobyp_rd0", bus.rd[31:0], 32'h0);
      chk("nobyp_rd1", bus.rd[63:32], 32'h0);
      chk("nobyp_busy", {30'b0, bus.rd_busy}, 32'h3);
    end
    tick();
    idle();
    #1 chk("wr_r3_next", bus.rd[31:0], 32'hA5A5_A5A5);

    for (int i = 0; i < 3; i++) begin
      bus.iss_valid = 1'b1;
      bus.iss_addr = (i == 0) ? 5'd4 : (i == 1) ? 5'd9 : 5'd12;
      tick();
    end
    bus.iss_valid = 1'b1; bus.iss_addr = 9; bus.flush = 1'b1;
    bus.we = 1'b1; bus.wa = 4; bus.wd = 32'h4444_4444;
    tick();
    idle(); set_ra(4, 9);
    #1;
    chk("flush_busy_4_9", {30'b0, bus.rd_busy}, 32'h2);
    chk("flush_wr_r4", bus.rd[31:0], 32'h4444_4444);
    set_ra(12, 8);
    #1 chk("flush_busy_12_8", {30'b0, bus.rd_busy}, 32'h0);

    bus.we = 1'b1; bus.wa = 28; bus.wd = 32'hFFFF_0000;
    tick();
    bus.wa = 29; bus.wd = 32'hFFFF_0001; bus.iss_valid = 1'b1; bus.iss_addr = 6;
    tick();
    reset = 1'b1;
    bus.we = 1'b1; bus.wa = 7; bus.wd = 32'h7777_7777;
    bus.iss_valid = 1'b1; bus.iss_addr = 10;
    tick();
    reset = 1'b0; idle(); set_ra(7, 6);
    #1;
    chk("rst_mid_r7", bus.rd[31:0], 32'h0);
    chk("rst_mid_busy", {30'b0, bus.rd_busy}, 32'h0);
    set_ra(28, 29);
    #1;
    chk("rst_mid_gp", bus.rd[31:0], 32'h0000_1800);
    chk("rst_mid_sp", bus.rd[63:32], 32'h0000_2ffc);

    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 63) == 0);
      bus.we        = 1'($urandom_range(0, 1));
      bus.wa        = AW'($urandom_range(0, DEPTH - 1));
      bus.wd        = $urandom;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.flush     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) set_ra(bus.wa, bus.wa);
      else set_ra(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    reset = 1'b0; idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
